// File: rtl/chan_router_pkg.sv
// ---------------------------------------------------------------------------
// chan_router_pkg
//   Shared types and helpers for the channel port router.
//   - CHAN_ADDR_W / DATA_W : host channel address and data widths
//   - ENTRY_W              : width of one buffered h2f entry {addr, data}
//   - h2f_entry_t          : packed {addr, data} entry held by the tag FIFO
//   - port_sel()           : extracts the port number from the top
//                            port_bits bits of a channel address
// ---------------------------------------------------------------------------
package chan_router_pkg;

  localparam int CHAN_ADDR_W = 7;
  localparam int DATA_W      = 8;
  localparam int ENTRY_W     = CHAN_ADDR_W + DATA_W;

  typedef struct packed {
    logic [CHAN_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]      data;
  } h2f_entry_t;

  // Port number = addr[6:7-port_bits], returned zero-extended.
  function automatic int unsigned port_sel(input logic [CHAN_ADDR_W-1:0] addr,
                                           input int unsigned            port_bits);
    logic [CHAN_ADDR_W-1:0] shifted;
    shifted = addr >> (CHAN_ADDR_W - port_bits);
    return {{(32-CHAN_ADDR_W){1'b0}}, shifted};
  endfunction

endpackage

// File: rtl/chan_tag_fifo.sv
// ---------------------------------------------------------------------------
// chan_tag_fifo
//   Two-entry synchronous FIFO holding address-tagged host write bytes.
//   Ports:
//     clk_in, reset_in : clock and synchronous active-high reset (flushes)
//     push_in          : write request; accepted only when ready_out=1
//     push_entry_in    : {addr, data} captured on an accepted push
//     pop_in           : remove the head entry; ignored when empty
//     head_out         : current head entry (valid when empty_out=0)
//     empty_out        : no entries held
//     ready_out        : registered !full
// ---------------------------------------------------------------------------
module chan_tag_fifo
  import chan_router_pkg::*;
(
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       push_in,
  input  h2f_entry_t push_entry_in,
  input  logic       pop_in,
  output h2f_entry_t head_out,
  output logic       empty_out,
  output logic       ready_out
);

  localparam int DEPTH = 2;

  h2f_entry_t mem_q [DEPTH];
  h2f_entry_t mem_d [DEPTH];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       ready_q, ready_d;
  logic       do_push, do_pop;

  always_comb begin
    // Ready is the registered !full, so a push can never land on a full FIFO.
    do_push  = push_in && ready_q;
    do_pop   = pop_in && (count_q != 2'd0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry_in;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Computed from the next count so ready tracks fullness with no bubble.
    ready_d = (count_d != 2'(DEPTH));
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ready_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  assign head_out  = mem_q[rd_ptr_q];
  assign empty_out = (count_q == 2'd0);
  assign ready_out = ready_q;

endmodule

// File: rtl/chan_port_router.sv
// ---------------------------------------------------------------------------
// chan_port_router
//   Shares one host channel interface among 2^PORT_BITS application ports.
//   The top PORT_BITS bits of the channel address select a port; the low
//   bits form the port-local channel address.
//   Host side : chanAddr_in, h2fData_in/h2fValid_in/h2fReady_out,
//               f2hData_out/f2hValid_out/f2hReady_in
//   Port side : portChanAddr_out, portH2fData_out (shared),
//               portH2fValid_out/portH2fReady_in (per port, one-hot valid),
//               portF2hData_in/portF2hValid_in/portF2hReady_out (per port)
//   Host writes go through a 2-entry tag FIFO. Reads are combinational from
//   the live address but only open once the FIFO is empty, so a read never
//   overtakes an earlier write.
// ---------------------------------------------------------------------------
module chan_port_router
  import chan_router_pkg::*;
#(
  parameter int                       PORT_BITS  = 2,
  parameter logic [(2**PORT_BITS)-1:0] PORT_MASK = {(2**PORT_BITS){1'b1}},
  parameter logic [7:0]               EMPTY_DATA = 8'h00
) (
  input  logic                                  clk_in,
  input  logic                                  reset_in,
  input  logic [CHAN_ADDR_W-1:0]                chanAddr_in,
  input  logic [DATA_W-1:0]                     h2fData_in,
  input  logic                                  h2fValid_in,
  output logic                                  h2fReady_out,
  output logic [DATA_W-1:0]                     f2hData_out,
  output logic                                  f2hValid_out,
  input  logic                                  f2hReady_in,
  output logic [CHAN_ADDR_W-PORT_BITS-1:0]      portChanAddr_out,
  output logic [DATA_W-1:0]                     portH2fData_out,
  output logic [(2**PORT_BITS)-1:0]             portH2fValid_out,
  input  logic [(2**PORT_BITS)-1:0]             portH2fReady_in,
  input  logic [DATA_W*(2**PORT_BITS)-1:0]      portF2hData_in,
  input  logic [(2**PORT_BITS)-1:0]             portF2hValid_in,
  output logic [(2**PORT_BITS)-1:0]             portF2hReady_out
);

  localparam int NUM_PORTS = 2**PORT_BITS;
  localparam int LOCAL_W   = CHAN_ADDR_W - PORT_BITS;

  h2f_entry_t           push_entry;
  h2f_entry_t           head;
  logic                 fifo_empty;
  logic                 fifo_ready;
  logic                 push;
  logic                 pop;
  logic [PORT_BITS-1:0] h2f_sel;
  logic [PORT_BITS-1:0] f2h_sel;
  logic                 f2h_gate;
  logic [DATA_W-1:0]    f2h_data_arr [NUM_PORTS];

  // ---------------------------------------------------------------- h2f FIFO
  assign push_entry = '{addr: chanAddr_in, data: h2fData_in};
  assign push       = h2fValid_in && fifo_ready;

  chan_tag_fifo u_fifo (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .push_in       (push),
    .push_entry_in (push_entry),
    .pop_in        (pop),
    .head_out      (head),
    .empty_out     (fifo_empty),
    .ready_out     (fifo_ready)
  );

  assign h2fReady_out = fifo_ready;

  // Delivery decode works on the captured tag, not the live address, so a
  // buffered byte reaches the port it was written to.
  assign h2f_sel = PORT_BITS'(port_sel(head.addr, PORT_BITS));

  // An unpopulated target has nobody to accept it: sink it immediately.
  assign pop = !fifo_empty && (!PORT_MASK[h2f_sel] || portH2fReady_in[h2f_sel]);

  // ---------------------------------------------------------------- f2h path
  assign f2h_sel  = PORT_BITS'(port_sel(chanAddr_in, PORT_BITS));
  assign f2h_gate = fifo_empty && !reset_in;

  // ------------------------------------------------------- per-port strobes
  genvar gi;
  for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign f2h_data_arr[gi]     = portF2hData_in[gi*DATA_W +: DATA_W];
    assign portH2fValid_out[gi] = !reset_in && !fifo_empty && PORT_MASK[gi] &&
                                  (h2f_sel == PORT_BITS'(gi));
    assign portF2hReady_out[gi] = f2h_gate && f2hReady_in && PORT_MASK[gi] &&
                                  (f2h_sel == PORT_BITS'(gi));
  end

  always_comb begin
    f2hData_out  = EMPTY_DATA;
    f2hValid_out = 1'b0;
    if (PORT_MASK[f2h_sel]) begin
      f2hData_out  = f2h_data_arr[f2h_sel];
      f2hValid_out = f2h_gate && portF2hValid_in[f2h_sel];
    end else begin
      // Unpopulated ports always answer with the filler byte.
      f2hValid_out = f2h_gate;
    end
  end

  // Shared port address: head tag while writes are pending, else the live
  // address so a reading port sees where the host is pointing.
  always_comb begin
    portChanAddr_out = '0;
    portH2fData_out  = '0;
    if (!reset_in) begin
      portH2fData_out  = head.data;
      portChanAddr_out = fifo_empty ? chanAddr_in[LOCAL_W-1:0]
                                    : head.addr[LOCAL_W-1:0];
    end
  end

endmodule

// File: doc/chan_port_router.md
Name: chan_port_router

Overview:
- Shares the single host channel interface from comm_fpga_epp among 2^PORT_BITS application ports.
- Ports are selected by the top PORT_BITS bits of the 7-bit channel address; each port sees a local channel address made of the low bits.
- The h2f path is buffered by a 2-entry address-tagged FIFO.
- The f2h path is routed to the selected port, and f2h reads are held off until all earlier writes have been delivered, so write-then-read order is preserved.

Parameters:
- PORT_BITS, 2, number of port-select bits taken from chanAddr[6:7-PORT_BITS]; NUM_PORTS = 2^PORT_BITS.
- PORT_MASK, 4'b1111 (width NUM_PORTS), bit p = 1 means port p is populated.
- EMPTY_DATA, 8'h00, byte returned on f2h reads from an unpopulated port.

Ports:
- clk_in  in  1  single clock; all logic is on its rising edge.
- reset_in  in  1  synchronous, active-high reset.
- chanAddr_in  in  7  host channel address.
- h2fData_in  in  8  host write data.
- h2fValid_in  in  1  host write valid.
- h2fReady_out  out  1  router can accept a host write byte.
- f2hData_out  out  8  host read data.
- f2hValid_out  out  1  host read data valid.
- f2hReady_in  in  1  host consumes the read byte on this edge.
- portChanAddr_out  out  7-PORT_BITS  local channel address, shared by all ports.
- portH2fData_out  out  8  write data, shared by all ports.
- portH2fValid_out  out  NUM_PORTS  one-hot write valid.
- portH2fReady_in  in  NUM_PORTS  per-port write ready.
- portF2hData_in  in  8*NUM_PORTS  per-port read data; port p occupies bits [8p+7:8p].
- portF2hValid_in  in  NUM_PORTS  per-port read valid.
- portF2hReady_out  out  NUM_PORTS  one-hot read ready.

Behaviour:
- Reset: clock is clk_in; reset is synchronous and active-high on reset_in.
  - While reset_in=1: FIFO is flushed, h2fReady_out=0, f2hValid_out=0, all portH2fValid_out=0, all portF2hReady_out=0, portChanAddr_out=0, portH2fData_out=0.
  - If reset_in is asserted mid-transfer, buffered bytes are discarded and are never delivered.
- h2f FIFO:
  - 2 entries, each {addr[6:0], data[7:0]}.
  - A push happens on an edge where h2fValid_in=1 and h2fReady_out=1; it captures the chanAddr_in value of that same cycle.
  - h2fReady_out = !full and is a registered (flop) output, not combinational.
  - Full and empty are tracked with a 2-bit count; a simultaneous push and pop when full is not allowed, because ready is already low.
- h2f delivery:
  - The FIFO head drives portChanAddr_out = head.addr[6-PORT_BITS:0] and portH2fData_out = head.data.
  - portH2fValid_out[p] = !empty && head.addr[6:7-PORT_BITS]==p && PORT_MASK[p].
  - Pop when the selected port has portH2fReady_in=1.
  - If the head targets an unpopulated port, it is popped in one cycle with no port strobe (byte is sunk).
  - Latency: a byte pushed at edge N is visible at the port from cycle N+1.
  - Sustained throughput is 1 byte/clk when the port is always ready.
  - Bytes to different ports are delivered strictly in FIFO order; there is no reordering.
- f2h path:
  - The port is selected from the live chanAddr_in[6:7-PORT_BITS].
  - The path is combinational; there is no prefetch, so changing channel never loses a byte.
  - Gate g = FIFO empty.
  - f2hValid_out = g && (PORT_MASK[sel] ? portF2hValid_in[sel] : 1).
  - f2hData_out = PORT_MASK[sel] ? portF2hData_in[sel] : EMPTY_DATA.
  - portF2hReady_out[sel] = g && f2hReady_in && PORT_MASK[sel]; all other bits are 0.
  - portChanAddr_out tracks chanAddr_in's low bits when the FIFO is empty, and the head address otherwise.
- Simultaneous h2f push and f2h request: the push wins. The read stays gated until the FIFO drains, at least 1 cycle after the last pop.
- Channel-address changes while the FIFO holds data: each buffered byte keeps its captured address tag.

Decomposition:
- Shared package chan_router_pkg:
  - CHAN_ADDR_W=7, DATA_W=8.
  - the h2f entry struct/concatenation width {addr, data} = 15 bits.
  - function port_sel(addr, PORT_BITS).
- Sub-module chan_tag_fifo: 2-deep synchronous FIFO, width 15, with registered ready/!full; clk_in, reset_in.
- The router top holds the decode, gating and f2h mux.

Test Plan:
1. Reset/idle: hold reset_in=1 for 3 clk with h2fValid_in=1 -> h2fReady_out=0, no port strobes, f2hValid_out=0; 1 clk after release -> h2fReady_out=1.
2. Burst write:
   - Stimulus: chanAddr 7'h25, bytes 8'h11,8'h22,8'h33 on consecutive cycles, port 1 always ready.
   - Response: portH2fValid_out=4'b0010 with local addr 5'h05; bytes are delivered on consecutive cycles starting 1 cycle after the first accept; 3 pops total.
3. Backpressure:
   - Stimulus: port 0 ready=0, host writes 4 bytes to chan 7'h02.
   - Response: h2fReady_out drops after 2 accepts; raising ready delivers the bytes in order with none lost or duplicated.
4. Ordering:
   - Stimulus: write 8'hAA to chan 7'h41, then in the next cycle request a read from chan 7'h41 (port 2 presents 8'h5C valid).
   - Response: f2hValid_out stays 0 until port 2 takes 8'hAA; then 8'h5C is returned and portF2hReady_out=4'b0100 on consume.
5. Unpopulated port:
   - Config: PORT_MASK=4'b0111.
   - Response: a write to chan 7'h70 is sunk with no strobe; a read from 7'h7F returns 8'h00 valid every cycle.
6. Address change/reset mid-flight:
   - Stimulus: write 8'h10 to chan 7'h03 and 8'h20 to chan 7'h23 back-to-back, port 0 stalled.
   - Response: 8'h20 still reaches port 1 with local addr 5'h03.
   - Stimulus: assert reset_in while both bytes are buffered.
   - Response: neither byte is delivered.
